flex_buffer: RTL and testbench



---
 rtl/flex_buffer.sv | 115 +++++++++++
 tb/tb_flex_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_buffer.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module flex_buffer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     write_en,
  input  logic                     read_en,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [CW-1:0] CntOne = CW'(1);
  localparam logic [CW-1:0] CntMax = CW'(DEPTH);
  localparam logic [CW-1:0] AfThr  = CW'(AF_THRESH);
  localparam logic [CW-1:0] AeThr  = CW'(AE_THRESH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_ok, wr_ok, mem_we;
  logic [WIDTH-1:0] head;

  assign full         = (count_q == CntMax);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AfThr);
  assign almost_empty = (count_q <= AeThr);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign head = mem[rptr_q];
  assign dout = (FWFT != 0) ? (empty ? '0 : head) : dout_q;

  // A full buffer still takes a write when a pop frees a slot in the same cycle.
  assign rd_ok = read_en && !empty;
  assign wr_ok = write_en && (!full || rd_ok);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
    if (clear) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      dout_d      = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PtrOne;
      end
      if (rd_ok) begin
        rptr_d = rptr_q + PtrOne;
        dout_d = head;
      end
      if (wr_ok && !rd_ok) count_d = count_q + CntOne;
      if (rd_ok && !wr_ok) count_d = count_q - CntOne;
      if (write_en && !wr_ok) overflow_d = 1'b1;
      if (read_en && !rd_ok) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset and clear.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) mem[wptr_q] <= din;
  end

endmodule

// File: tb/tb_flex_buffer.sv
// Drives a standard-read and a FWFT instance with identical stimulus and checks
// both against a queue-based model of the buffer.
module tb_flex_buffer;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst, we, re, clr;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic [3:0]  cnt0, cnt1;
  logic        full0, empty0, af0, ae0, ovf0, unf0;
  logic        full1, empty1, af1, ae1, ovf1, unf1;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  logic        m_ovf, m_unf;
  logic [31:0] m_dout0;

  always #5 clk = ~clk;

  flex_buffer #(.WIDTH(32), .DEPTH(D), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) u0 (
    .CLK(clk), .RST(rst), .write_en(we), .read_en(re), .clear(clr), .din(din),
    .dout(dout0), .count(cnt0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
  );

  flex_buffer #(.WIDTH(32), .DEPTH(D), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u1 (
    .CLK(clk), .RST(rst), .write_en(we), .read_en(re), .clear(clr), .din(din),
    .dout(dout1), .count(cnt1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
  );

  // One clock edge: model consumes the inputs the DUT sampled, outputs sampled 1ns later.
  task automatic cycle();
    @(posedge clk);
    if (rst || clr) begin
      q.delete();
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      m_dout0 = '0;
    end else begin
      bit rd, wr;
      rd = re && (q.size() != 0);
      wr = we && ((q.size() < D) || rd);
      if (rd) m_dout0 = q.pop_front();
      if (wr) q.push_back(din);
      if (we && !wr) m_ovf = 1'b1;
      if (re && !rd) m_unf = 1'b1;
    end
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    we = 1'b1; din = v;
    cycle();
    we = 1'b0;
  endtask

  task automatic pop();
    re = 1'b1;
    cycle();
    re = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if ({cnt0, full0, empty0, af0, ae0, ovf0, unf0} !== {4'd0, 6'b010100}) begin
      errors++;
      $display("FAIL reset_flags: got %b expected %b",
               {cnt0, full0, empty0, af0, ae0, ovf0, unf0}, {4'd0, 6'b010100});
    end
    checks++;
    if (dout0 !== 32'd0 || dout1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_dout: got %0h/%0h expected 0/0", dout0, dout1);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      push(32'(10 * i));
      checks++;
      if ({cnt0, ae0, af0, full0, ovf0} !== {4'(i), i <= 1, i >= 6, i == 8, 1'b0}) begin
        errors++;
        $display("FAIL fill_%0d: got cnt=%0d ae=%b af=%b full=%b ovf=%b expected cnt=%0d",
                 i, cnt0, ae0, af0, full0, ovf0, i);
      end
    end
  endtask

  task automatic test_overflow_drain();
    push(32'd9999);
    checks++;
    if (ovf0 !== 1'b1 || cnt0 !== 4'd8 || ovf1 !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got ovf=%b cnt=%0d expected ovf=1 cnt=8", ovf0, cnt0);
    end
    for (int i = 1; i <= 8; i++) begin
      pop();
      checks++;
      if (dout0 !== 32'(10 * i) || dout1 !== (i < 8 ? 32'(10 * (i + 1)) : 32'd0)) begin
        errors++;
        $display("FAIL drain_%0d: got %0d/%0d expected %0d", i, dout0, dout1, 10 * i);
      end
      checks++;
      if (ovf0 !== 1'b1) begin
        errors++;
        $display("FAIL overflow_sticky_%0d: got %b expected 1", i, ovf0);
      end
    end
    checks++;
    if (empty0 !== 1'b1 || unf0 !== 1'b0) begin
      errors++;
      $display("FAIL drained_empty: got empty=%b unf=%b expected 1/0", empty0, unf0);
    end
    pop();
    checks++;
    if (unf0 !== 1'b1 || dout0 !== 32'd80 || dout1 !== 32'd0) begin
      errors++;
      $display("FAIL underflow: got unf=%b dout=%0d expected unf=1 dout=80", unf0, dout0);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) push($urandom);
    for (int i = 0; i < 6; i++) begin
      pop();
      checks++;
      if (dout0 !== m_dout0) begin
        errors++;
        $display("FAIL wrap_pre_%0d: got %0h expected %0h", i, dout0, m_dout0);
      end
    end
    for (int i = 1; i <= 8; i++) push(32'(100 * i));
    checks++;
    if (full0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_full: got %b expected 1", full0);
    end
    for (int i = 1; i <= 8; i++) begin
      pop();
      checks++;
      if (dout0 !== 32'(100 * i)) begin
        errors++;
        $display("FAIL wrap_%0d: got %0d expected %0d", i, dout0, 100 * i);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_clear();
    we = 1'b1; re = 1'b1; din = 32'd40;
    cycle();
    we = 1'b0; re = 1'b0;
    checks++;
    if (cnt0 !== 4'd1 || unf0 !== 1'b1 || dout1 !== 32'd40) begin
      errors++;
      $display("FAIL simul_empty: got cnt=%0d unf=%b head=%0d expected 1/1/40",
               cnt0, unf0, dout1);
    end
    for (int i = 41; i <= 47; i++) push(32'(i));
    we = 1'b1; re = 1'b1; din = 32'd99;
    cycle();
    we = 1'b0; re = 1'b0;
    checks++;
    if (cnt0 !== 4'd8 || full0 !== 1'b1 || dout0 !== 32'd40 || ovf0 !== 1'b0) begin
      errors++;
      $display("FAIL simul_full: got cnt=%0d full=%b dout=%0d ovf=%b expected 8/1/40/0",
               cnt0, full0, dout0, ovf0);
    end
    for (int i = 0; i < 8; i++) begin
      pop();
      checks++;
      if (dout0 !== (i < 7 ? 32'(41 + i) : 32'd99)) begin
        errors++;
        $display("FAIL simul_order_%0d: got %0d expected %0d", i, dout0,
                 i < 7 ? 41 + i : 99);
      end
    end
  endtask

  task automatic test_fwft();
    do_clear();
    push(32'd5);
    checks++;
    if (dout1 !== 32'd5 || dout0 !== 32'd0) begin
      errors++;
      $display("FAIL fwft_visible: got %0d/%0d expected 5/0", dout1, dout0);
    end
    re = 1'b1;
    #1;
    checks++;
    if (dout1 !== 32'd5) begin
      errors++;
      $display("FAIL fwft_zero_latency: got %0d expected 5", dout1);
    end
    cycle();
    re = 1'b0;
    checks++;
    if (dout1 !== 32'd0 || empty1 !== 1'b1 || dout0 !== 32'd5) begin
      errors++;
      $display("FAIL fwft_popped: got %0d empty=%b std=%0d expected 0/1/5",
               dout1, empty1, dout0);
    end
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 9; i++) push(32'(200 + i));
    for (int i = 0; i < 4; i++) pop();
    checks++;
    if (cnt0 !== 4'd4 || ovf0 !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got cnt=%0d ovf=%b expected 4/1", cnt0, ovf0);
    end
    clr = 1'b1; we = 1'b1; din = 32'd777;
    cycle();
    clr = 1'b0; we = 1'b0;
    checks++;
    if ({cnt0, empty0, ovf0, unf0} !== {4'd0, 3'b100} || dout0 !== 32'd0 ||
        dout1 !== 32'd0) begin
      errors++;
      $display("FAIL clear_flush: got cnt=%0d empty=%b ovf=%b dout=%0d expected 0/1/0/0",
               cnt0, empty0, ovf0, dout0);
    end
    cycle();
    checks++;
    if (cnt0 !== 4'd0) begin
      errors++;
      $display("FAIL clear_write_discarded: got cnt=%0d expected 0", cnt0);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [9:0] exp0, exp1;
      we  = ($urandom_range(0, 99) < 55);
      re  = ($urandom_range(0, 99) < 50);
      clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 99) == 0);
      din = $urandom;
      cycle();
      exp0 = {4'(q.size()), q.size() == D, q.size() == 0, q.size() >= 6, q.size() <= 1,
              m_ovf, m_unf};
      exp1 = exp0;
      checks++;
      if ({cnt0, full0, empty0, af0, ae0, ovf0, unf0} !== exp0) begin
        errors++;
        $display("FAIL rand_flags0_%0d: got %b expected %b", n,
                 {cnt0, full0, empty0, af0, ae0, ovf0, unf0}, exp0);
      end
      checks++;
      if ({cnt1, full1, empty1, af1, ae1, ovf1, unf1} !== exp1) begin
        errors++;
        $display("FAIL rand_flags1_%0d: got %b expected %b", n,
                 {cnt1, full1, empty1, af1, ae1, ovf1, unf1}, exp1);
      end
      checks++;
      if (dout0 !== m_dout0 || dout1 !== (q.size() != 0 ? q[0] : 32'd0)) begin
        errors++;
        $display("FAIL rand_dout_%0d: got %0h/%0h expected %0h/%0h", n, dout0, dout1,
                 m_dout0, q.size() != 0 ? q[0] : 32'd0);
      end
    end
    we = 1'b0; re = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; din = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_overflow_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
